input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 17 +
 rtl/input_conditioner_if.sv | 31 +++
 rtl/input_conditioner_debounce_channel.sv | 74 +++++++
 rtl/input_conditioner.sv | 62 ++++++
 tb/tb_input_conditioner.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner.
// Debounce length is derived from clock rate and a time in ms.
package input_cond_pkg;

    localparam int CLK_HZ          = 25_000_000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int N_CH_DEF        = 13;

    function automatic int debounce_cycles(
        input int clk_hz,
        input int ms
    );
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin/level bundle between the raw pads and the conditioned consumers.
// master drives the pins, slave is the conditioner.
interface input_conditioner_if
    import input_cond_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);

    logic [N_CH-1:0] pin_in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            any_rise;

    modport master (
        output pin_in,
        input  level,
        input  rise,
        input  fall,
        input  any_rise
    );

    modport slave (
        input  pin_in,
        output level,
        output rise,
        output fall,
        output any_rise
    );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned bit: synchronizer, debounce counter, level, edges.
// rise_d is the next-cycle rise so the parent can register any_rise.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_d
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   cond;
    logic                   differ;
    logic                   toggle;
    logic                   fall_d;

    // Reset to the idle pin value so release never looks like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INVERT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    always_comb begin
        cond   = sync_q[SYNC_STAGES-1] ^ INVERT;
        differ = (cond != level);
        toggle = differ && (cnt_q == CNT_MAX);
        rise_d = toggle & ~level;
        fall_d = toggle & level;
        cnt_d  = cnt_q;
        unique case (1'b1)
            !differ: cnt_d = '0;
            toggle:  cnt_d = '0;
            default: cnt_d = cnt_q + CW'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            level <= level ^ toggle;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// N_CH independent debounced inputs plus a registered any_rise flag.
// Defaults give a 10 ms debounce at 25 MHz.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int              N_CH            = N_CH_DEF,
    parameter int              SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int              DEBOUNCE_CYCLES =
        debounce_cycles(CLK_HZ, DEBOUNCE_MS),
    parameter logic [N_CH-1:0] INVERT_MASK     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input_conditioner_if.slave  io
);

    if (N_CH < 1) begin : g_bad_nch
        $error("input_conditioner: N_CH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;
    logic [N_CH-1:0] rise_d_w;
    logic            any_rise_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT_MASK[i])
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin    (io.pin_in[i]),
            .level  (level_w[i]),
            .rise   (rise_w[i]),
            .fall   (fall_w[i]),
            .rise_d (rise_d_w[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_rise_q <= 1'b0;
        end else begin
            any_rise_q <= |rise_d_w;
        end
    end

    assign io.level    = level_w;
    assign io.rise     = rise_w;
    assign io.fall     = fall_w;
    assign io.any_rise = any_rise_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: 4 channels, 2 sync stages, 8-cycle debounce,
// channel 3 active-low. Level changes land 10 edges after a pin step.
module tb_input_conditioner;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    input_conditioner_if #(.N_CH(4)) io();

    input_conditioner #(
        .N_CH            (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .INVERT_MASK     (4'b1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] lvl,
                             input logic [3:0] r, input logic [3:0] f,
                             input logic a);
        check({tag, ".level"}, io.level, lvl);
        check({tag, ".rise"}, io.rise, r);
        check({tag, ".fall"}, io.fall, f);
        check({tag, ".any_rise"}, {3'b000, io.any_rise}, {3'b000, a});
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        io.pin_in = 4'b1000;

        // Reset state and quiet release with an idle active-low pin
        tick();
        tick();
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("post_release", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end

        // Clean step on channel 0
        io.pin_in[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("ch0_wait.level", io.level, 4'b0000);
        end
        tick();
        check_all("ch0_rise", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        tick();
        check_all("ch0_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        // Short pulse on channel 1 is rejected
        io.pin_in[1] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        io.pin_in[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_all("ch1_glitch", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        end

        // Bouncing channel 2, then held high
        for (int t = 0; t < 12; t++) begin
            io.pin_in[2] = ~io.pin_in[2];
            for (int i = 0; i < 3; i++) begin
                tick();
                check_all("ch2_bounce", 4'b0001, 4'b0000, 4'b0000,
                          1'b0);
            end
        end
        io.pin_in[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("ch2_wait.level", io.level, 4'b0001);
        end
        tick();
        check_all("ch2_rise", 4'b0101, 4'b0100, 4'b0000, 1'b1);

        // Active-low press and release on channel 3
        io.pin_in[3] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("ch3_press_wait.level", io.level, 4'b0101);
        end
        tick();
        check_all("ch3_press", 4'b1101, 4'b1000, 4'b0000, 1'b1);
        io.pin_in[3] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_all("ch3_rel_wait", 4'b1101, 4'b0000, 4'b0000, 1'b0);
        end
        tick();
        check_all("ch3_release", 4'b0101, 4'b0000, 4'b1000, 1'b0);
        tick();
        check_all("ch3_after", 4'b0101, 4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of a pending channel-1 transition
        io.pin_in[1] = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        check_all("mid_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_all("rerun_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        tick();
        check_all("rerun_rise", 4'b0111, 4'b0111, 4'b0000, 1'b1);
        tick();
        check_all("rerun_after", 4'b0111, 4'b0000, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
